// File: rtl/fetch_unit_if.sv
// Fetch-to-imem/decode bus: imem address/data, redirect, and the decoded
// instruction fields with their valid/ready handshake.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_ready;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_pc;
  logic [4:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        shamt;
  logic [4:0]        alu_op;
  logic [16:0]       imm;
  logic [26:0]       target;
  logic [31:0]       fetch_count;

  modport master (
    output imem_addr, inst_valid, inst_pc, opcode, rd, rs, rt, shamt,
           alu_op, imm, target, fetch_count,
    input  imem_q, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_addr, inst_valid, inst_pc, opcode, rd, rs, rt, shamt,
           alu_op, imm, target, fetch_count,
    output imem_q, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem address, captures the word one cycle
// later and holds its decoded fields under a valid/ready handshake to decode.
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_capture;
  logic              w_accept;

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_valid;
  logic [31:0]       r_count;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_ISSUE;
    else       r_state <= w_next;
  end

  // Redirect overrides the next state and suppresses capture, but an
  // instruction handed over in the same cycle still counts as accepted.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        w_next    = S_HOLD;
        w_capture = 1'b1;
      end
      S_HOLD: begin
        if (bus.dec_ready) begin
          w_next   = S_WAIT;
          w_accept = 1'b1;
        end
      end
      default: w_next = S_ISSUE;
    endcase
    if (bus.redirect) begin
      w_next    = S_ISSUE;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_accept) r_count <= r_count + 32'd1;
      if (bus.redirect) begin
        r_pc    <= bus.redirect_pc;
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_ir      <= bus.imem_q;
        r_inst_pc <= r_pc;
        r_pc      <= r_pc + ADDR_W'(1);
        r_valid   <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.inst_valid  = r_valid;
  assign bus.inst_pc     = r_inst_pc;
  assign bus.opcode      = r_ir[31:27];
  assign bus.rd          = r_ir[26:22];
  assign bus.rs          = r_ir[21:17];
  assign bus.rt          = r_ir[16:12];
  assign bus.shamt       = r_ir[11:7];
  assign bus.alu_op      = r_ir[6:2];
  assign bus.imm         = r_ir[16:0];
  assign bus.target      = r_ir[26:0];
  assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem array, cycle-level reference model of the fetch
// timing, per-cycle comparison plus directed literal expectations.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 12;

  logic clock;
  logic reset;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(12'h000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:4095];

  always @(posedge clock) bus.imem_q <= mem[bus.imem_addr];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an instruction appears a fixed number of edges after
  // issue starts (2 after reset/redirect, 1 after an accept).
  logic              model_ok = 1'b0;
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_ipc;
  logic [31:0]       m_ir;
  logic [31:0]       m_cnt;
  logic              m_valid;
  int                m_wait;

  always @(posedge clock) begin
    if (reset) begin
      m_pc = '0; m_ipc = '0; m_ir = '0; m_cnt = '0; m_valid = 1'b0;
      m_wait = 2; model_ok = 1'b1;
    end else if (model_ok) begin
      if (m_valid && bus.dec_ready) m_cnt = m_cnt + 1;
      if (bus.redirect) begin
        m_pc = bus.redirect_pc; m_valid = 1'b0; m_wait = 2;
      end else if (m_valid) begin
        if (bus.dec_ready) begin m_valid = 1'b0; m_wait = 1; end
      end else begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_ir = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 1; m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      chk("inst_valid",  {31'd0, bus.inst_valid}, {31'd0, m_valid});
      chk("inst_pc",     {20'd0, bus.inst_pc},    {20'd0, m_ipc});
      chk("imem_addr",   {20'd0, bus.imem_addr},  {20'd0, m_pc});
      chk("opcode",      {27'd0, bus.opcode},     {27'd0, m_ir[31:27]});
      chk("rd",          {27'd0, bus.rd},         {27'd0, m_ir[26:22]});
      chk("rs",          {27'd0, bus.rs},         {27'd0, m_ir[21:17]});
      chk("rt",          {27'd0, bus.rt},         {27'd0, m_ir[16:12]});
      chk("shamt",       {27'd0, bus.shamt},      {27'd0, m_ir[11:7]});
      chk("alu_op",      {27'd0, bus.alu_op},     {27'd0, m_ir[6:2]});
      chk("imm",         {15'd0, bus.imm},        {15'd0, m_ir[16:0]});
      chk("target",      {5'd0, bus.target},      {5'd0, m_ir[26:0]});
      chk("fetch_count", bus.fetch_count,         m_cnt);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h2840_0005;

    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_ready   = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_count", bus.fetch_count, 32'd0);
    chk("rst_addr",  {20'd0, bus.imem_addr}, 32'd0);
    chk("rst_imm",   {15'd0, bus.imm}, 32'd0);

    // First instruction: issue at edge 1, valid after edge 2
    reset = 1'b0;
    tick();
    chk("t1_valid_e1", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("t1_opcode", {27'd0, bus.opcode}, 32'd5);
    chk("t1_rd",     {27'd0, bus.rd}, 32'd1);
    chk("t1_rs",     {27'd0, bus.rs}, 32'd0);
    chk("t1_imm",    {15'd0, bus.imm}, 32'd5);
    chk("t1_pc",     {20'd0, bus.inst_pc}, 32'd0);

    // Straight-line at full rate
    tick();
    chk("t2_count1", bus.fetch_count, 32'd1);
    chk("t2_gap",    {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("t2_pc1",    {20'd0, bus.inst_pc}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("t2_pc3",    {20'd0, bus.inst_pc}, 32'd3);
    tick();
    chk("t2_count4", bus.fetch_count, 32'd4);
    tick();
    chk("t3_pc4",    {20'd0, bus.inst_pc}, 32'd4);

    // Stall decode for 5 cycles
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_hold_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("t3_hold_pc",    {20'd0, bus.inst_pc}, 32'd4);
    chk("t3_hold_imm",   {15'd0, bus.imm}, 32'd4);
    chk("t3_hold_count", bus.fetch_count, 32'd4);
    bus.dec_ready = 1'b1;
    tick();
    chk("t3_count5", bus.fetch_count, 32'd5);
    tick();
    chk("t3_pc5",    {20'd0, bus.inst_pc}, 32'd5);

    // Redirect while in S_WAIT
    tick();
    chk("t4_count6", bus.fetch_count, 32'd6);
    bus.redirect = 1'b1; bus.redirect_pc = 12'h040;
    tick();
    bus.redirect = 1'b0;
    chk("t4_addr", {20'd0, bus.imem_addr}, 32'h040);
    chk("t4_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick(); tick();
    chk("t4_pc",    {20'd0, bus.inst_pc}, 32'h040);
    chk("t4_count", bus.fetch_count, 32'd6);

    // Redirect coincident with accept, then back-to-back redirect to 0xFFF
    bus.redirect = 1'b1; bus.redirect_pc = 12'h200;
    tick();
    chk("t4b_count7", bus.fetch_count, 32'd7);
    bus.redirect_pc = 12'hFFF;
    tick();
    bus.redirect = 1'b0;
    tick(); tick();
    chk("t5_pcfff", {20'd0, bus.inst_pc}, 32'hFFF);
    chk("t5_wrap_addr", {20'd0, bus.imem_addr}, 32'h000);
    tick(); tick();
    chk("t5_pc0",   {20'd0, bus.inst_pc}, 32'h000);
    chk("t5_count", bus.fetch_count, 32'd8);

    // Redirect in S_HOLD without ready: not counted
    bus.dec_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 12'h010;
    tick();
    bus.redirect = 1'b0; bus.dec_ready = 1'b1;
    chk("t4c_count", bus.fetch_count, 32'd8);
    tick(); tick();
    chk("t4c_pc", {20'd0, bus.inst_pc}, 32'h010);

    // Reset while holding with ready asserted
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("t6_count", bus.fetch_count, 32'd0);
    chk("t6_addr",  {20'd0, bus.imem_addr}, 32'd0);
    chk("t6_op",    {27'd0, bus.opcode}, 32'd0);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 60; i++) begin
      bus.dec_ready   = 1'($urandom_range(0, 1));
      bus.redirect    = ($urandom_range(0, 7) == 0);
      bus.redirect_pc = 12'($urandom_range(0, 4095));
      tick();
    end
    bus.redirect = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
